// File: rtl/mul_share_pkg.sv
// Shared sizing and result-entry type for the shared 4x4 multiplier scheduler.
package mul_share_pkg;

  localparam int unsigned N_REQ      = 4;
  localparam int unsigned W          = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned ID_W       = $clog2(N_REQ);
  localparam int unsigned PROD_W     = 2 * W;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [PROD_W-1:0] product;
  } res_t;

endpackage

// File: rtl/mul_share_sched_if.sv
// Requester and response bundle of the shared multiplier scheduler.
interface mul_share_sched_if;
  import mul_share_pkg::*;

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [ID_W-1:0]    resp_id;
  logic [PROD_W-1:0]  resp_product;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_product, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_product, busy
  );

endinterface

// File: rtl/mul_result_fifo.sv
// First-word-fall-through result buffer; push into a full FIFO is legal only with a same-cycle pop.
module mul_result_fifo
  import mul_share_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  res_t             din_i,
  input  logic             pop_i,
  output res_t             dout_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  res_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CNT_W'(FIFO_DEPTH)) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler feeding one registered multiplier stage; results return tagged via a FWFT FIFO.
module mul_share_sched
  import mul_share_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  mul_share_sched_if.slave bus
);

  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_d;
  logic             s1_valid_q;
  logic [ID_W-1:0]  s1_id_q;
  logic [W-1:0]     s1_a_q;
  logic [W-1:0]     s1_b_q;

  logic [N_REQ-1:0] grant_c;
  logic [ID_W-1:0]  gnt_idx_c;
  logic [ID_W-1:0]  idx_c;
  logic             found_c;
  logic             xfer_c;
  logic             pop_c;
  logic             credit_ok_c;

  logic [CNT_W-1:0] fifo_count;
  logic             head_valid;
  res_t             head;
  res_t             push_entry;

  assign pop_c = head_valid & bus.resp_ready;

  // Results in flight (S1 plus FIFO) after this cycle's pop must leave room for one more.
  assign credit_ok_c = (32'(fifo_count) + 32'(s1_valid_q) - 32'(pop_c)) < FIFO_DEPTH;

  // Round-robin search from ptr; gated by rst_n so no grant is offered while in reset.
  always_comb begin
    grant_c   = '0;
    gnt_idx_c = ptr_q;
    idx_c     = '0;
    found_c   = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx_c = ID_W'((32'(ptr_q) + k) % N_REQ);
      if (!found_c && credit_ok_c && rst_n && bus.req_valid[idx_c]) begin
        found_c        = 1'b1;
        gnt_idx_c      = idx_c;
        grant_c[idx_c] = 1'b1;
      end
    end
  end

  assign bus.req_ready = grant_c;
  assign xfer_c        = |(bus.req_valid & grant_c);

  always_comb begin
    ptr_d = ptr_q;
    if (xfer_c) begin
      ptr_d = (gnt_idx_c == ID_W'(N_REQ - 1)) ? '0 : gnt_idx_c + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= xfer_c;
      if (xfer_c) begin
        s1_id_q <= gnt_idx_c;
        s1_a_q  <= bus.req_a[32'(gnt_idx_c) * W +: W];
        s1_b_q  <= bus.req_b[32'(gnt_idx_c) * W +: W];
      end
    end
  end

  always_comb begin
    push_entry.id      = s1_id_q;
    push_entry.product = {{W{1'b0}}, s1_a_q} * {{W{1'b0}}, s1_b_q};
  end

  mul_result_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s1_valid_q),
    .din_i   (push_entry),
    .pop_i   (pop_c),
    .dout_o  (head),
    .valid_o (head_valid),
    .count_o (fifo_count)
  );

  assign bus.resp_valid   = head_valid;
  assign bus.resp_id      = head.id;
  assign bus.resp_product = head.product;
  assign bus.busy         = s1_valid_q | head_valid;

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched: per-cycle queue model plus hand-computed spot checks.
module tb_mul_share_sched;
  import mul_share_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_share_sched_if bus();

  mul_share_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [W-1:0] a_arr [N_REQ];
  logic [W-1:0] b_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_pack
    assign bus.req_a[g*W +: W] = a_arr[g];
    assign bus.req_b[g*W +: W] = b_arr[g];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: every accepted request is an outstanding result; it becomes visible two cycles after acceptance.
  typedef struct {
    int id;
    int prod;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   m_ptr = 0;
  int   cyc   = 0;

  always @(negedge clk) begin
    int   os;
    int   ev;
    int   pop;
    int   gidx;
    int   exp_rdy;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
      chk("rst_req_ready", int'(bus.req_ready), 0);
      chk("rst_resp_valid", int'(bus.resp_valid), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_resp_id", int'(bus.resp_id), 0);
      chk("rst_resp_product", int'(bus.resp_product), 0);
    end else begin
      os      = q.size();
      ev      = (os > 0 && q[0].cyc <= cyc - 2) ? 1 : 0;
      pop     = (ev == 1 && bus.resp_ready) ? 1 : 0;
      gidx    = -1;
      exp_rdy = 0;
      if (os - pop < int'(FIFO_DEPTH)) begin
        for (int k = 0; k < int'(N_REQ); k++) begin
          int j;
          j = (m_ptr + k) % int'(N_REQ);
          if (gidx < 0 && bus.req_valid[j]) gidx = j;
        end
      end
      if (gidx >= 0) exp_rdy = 1 << gidx;
      chk("req_ready", int'(bus.req_ready), exp_rdy);
      chk("resp_valid", int'(bus.resp_valid), ev);
      chk("busy", int'(bus.busy), (os > 0) ? 1 : 0);
      if (ev == 1) begin
        chk("resp_id", int'(bus.resp_id), q[0].id);
        chk("resp_product", int'(bus.resp_product), q[0].prod);
      end
      if (pop == 1) void'(q.pop_front());
      if (gidx >= 0) begin
        e.id   = gidx;
        e.prod = int'(a_arr[gidx]) * int'(b_arr[gidx]);
        e.cyc  = cyc;
        q.push_back(e);
        m_ptr = (gidx + 1) % int'(N_REQ);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int e_id [4];
    int e_pr [4];
    rst_n          = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("init_resp_valid", int'(bus.resp_valid), 0);
    chk("init_busy", int'(bus.busy), 0);
    chk("init_req_ready", int'(bus.req_ready), 0);
    step(2);
    rst_n = 1'b1;

    // Single request: 15*15 from requester 2.
    a_arr[2] = 4'd15;
    b_arr[2] = 4'd15;
    bus.req_valid  = 4'b0100;
    bus.resp_ready = 1'b1;
    #1 chk("single_ready", int'(bus.req_ready), 4);
    step();
    bus.req_valid = '0;
    step();
    #1;
    chk("single_valid", int'(bus.resp_valid), 1);
    chk("single_id", int'(bus.resp_id), 2);
    chk("single_product", int'(bus.resp_product), 225);
    step(3);

    // All four requesters, edge operands, full-rate consumer.
    do_reset();
    a_arr[0] = 4'd0;  b_arr[0] = 4'd9;
    a_arr[1] = 4'd15; b_arr[1] = 4'd1;
    a_arr[2] = 4'd8;  b_arr[2] = 4'd8;
    a_arr[3] = 4'd7;  b_arr[3] = 4'd13;
    e_id = '{0, 1, 2, 3};
    e_pr = '{0, 15, 64, 91};
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 1'b1;
    #1 chk("rr_ready_c0", int'(bus.req_ready), 1);
    step();
    #1 chk("rr_ready_c1", int'(bus.req_ready), 2);
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      chk("rr_id", int'(bus.resp_id), e_id[k]);
      chk("rr_product", int'(bus.resp_product), e_pr[k]);
    end
    step(4);
    bus.req_valid = '0;
    step(4);

    // Back-pressure: two accepts, then stall until the consumer drains.
    do_reset();
    a_arr[0] = 4'd3; b_arr[0] = 4'd5;
    a_arr[1] = 4'd6; b_arr[1] = 4'd7;
    bus.req_valid = 4'b0011;
    #1 chk("bp_ready_c0", int'(bus.req_ready), 1);
    step();
    #1 chk("bp_ready_c1", int'(bus.req_ready), 2);
    step(3);
    #1;
    chk("bp_stalled", int'(bus.req_ready), 0);
    chk("bp_head_valid", int'(bus.resp_valid), 1);
    chk("bp_head_id", int'(bus.resp_id), 0);
    chk("bp_head_product", int'(bus.resp_product), 15);
    step();
    bus.resp_ready = 1'b1;
    #1 chk("bp_resume_ready", int'(bus.req_ready), 1);
    step();
    #1;
    chk("bp_second_id", int'(bus.resp_id), 1);
    chk("bp_second_product", int'(bus.resp_product), 42);
    bus.req_valid = '0;
    step(4);

    // Full FIFO drained while requester 3 streams: grant in the pop cycle, no bubbles.
    do_reset();
    a_arr[3] = 4'd9; b_arr[3] = 4'd11;
    bus.req_valid = 4'b1000;
    step(2);
    #1 chk("full_stalled", int'(bus.req_ready), 0);
    step();
    bus.resp_ready = 1'b1;
    #1;
    chk("full_pop_grant", int'(bus.req_ready), 8);
    chk("full_head_valid", int'(bus.resp_valid), 1);
    for (int k = 0; k < 10; k++) begin
      step();
      #1;
      chk("stream_ready", int'(bus.req_ready), 8);
      chk("stream_valid", int'(bus.resp_valid), 1);
      chk("stream_product", int'(bus.resp_product), 99);
    end

    // Asynchronous reset with S1 and FIFO both occupied.
    rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", int'(bus.resp_valid), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_req_ready", int'(bus.req_ready), 0);
    bus.req_valid = 4'b1111;
    step(2);
    rst_n = 1'b1;
    #1 chk("arst_first_grant", int'(bus.req_ready), 1);
    step(6);
    bus.req_valid = '0;
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
